// File: rtl/proj_kmer_window.sv
// rtl/proj_kmer_window.sv - streaming k-mer window generator with valid/ready on both sides
//
// Builds a sliding window of the last KMER_LEN accepted bases and presents one
// k-mer per accepted base once the window is full. The window sits between the
// nucleotide input stream and the MinHash hashing stage.
//
// Optional feature macro: KMER_CANONICAL_EN
//   defined   : a reverse-complement window runs in parallel and out_kmer is
//               the unsigned minimum of forward and reverse complement
//               (DATA_BITS must be 2 in this mode).
//   undefined : out_kmer is the forward window, out_rc is tied 0.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start_over     synchronous clear of window, counters and output stage
//   in_valid/in_ready/in_data/in_invalid/in_last
//                  input beat; in_invalid marks an ambiguous base (restarts
//                  the window), in_last marks the final base of a sequence
//   out_valid/out_ready/out_kmer/out_pos/out_last/out_rc
//                  registered k-mer output; newest base at the LSBs, out_pos is
//                  the 0-based sequence position of the newest base
//   fill_count     valid bases in the window, saturating at KMER_LEN

module proj_kmer_window #(
    parameter int DATA_BITS = 2,
    parameter int KMER_LEN  = 16,
    parameter int POS_BITS  = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_over,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_BITS-1:0]              in_data,
    input  logic                              in_invalid,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [KMER_LEN*DATA_BITS-1:0]     out_kmer,
    output logic [POS_BITS-1:0]               out_pos,
    output logic                              out_last,
    output logic                              out_rc,
    output logic [$clog2(KMER_LEN+1)-1:0]     fill_count
);

    localparam int W  = KMER_LEN * DATA_BITS;
    localparam int FW = $clog2(KMER_LEN + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(KMER_LEN);

    // Window and sequence state
    logic [W-1:0]        fwd_q, fwd_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic [POS_BITS-1:0] pos_q, pos_d;

    // Output stage
    logic                out_valid_q, out_valid_d;
    logic [W-1:0]        out_kmer_q, out_kmer_d;
    logic [POS_BITS-1:0] out_pos_q, out_pos_d;
    logic                out_last_q, out_last_d;
    logic                out_rc_q, out_rc_d;

    // Combinational helpers
    logic                beat;
    logic                load;
    logic [FW-1:0]       fill_inc;
    logic [W-1:0]        fwd_shift;
    logic [W-1:0]        cand_kmer;
    logic                cand_rc;

`ifdef KMER_CANONICAL_EN
    logic [W-1:0]         rc_q, rc_d;
    logic [W-1:0]         rc_shift;
    logic [DATA_BITS-1:0] comp_data;
`endif

    // The single output register may take a new beat whenever it is empty or
    // being drained this cycle, so full throughput has no bubbles.
    assign in_ready = !start_over && (!out_valid_q || out_ready);

    always_comb begin
        beat      = in_valid && in_ready;
        fill_inc  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
        fwd_shift = (fwd_q << DATA_BITS) | W'(in_data);

`ifdef KMER_CANONICAL_EN
        // Complemented base enters at the MSBs and the oldest leaves at the
        // LSBs, so rc_q always holds the reverse complement of fwd_q.
        comp_data = ~in_data;
        rc_shift  = (rc_q >> DATA_BITS) | {comp_data, {(W-DATA_BITS){1'b0}}};
        cand_rc   = rc_shift < fwd_shift;   // tie keeps the forward strand
        cand_kmer = cand_rc ? rc_shift : fwd_shift;
`else
        cand_rc   = 1'b0;
        cand_kmer = fwd_shift;
`endif

        load = beat && !in_invalid && (fill_inc == FILL_FULL);
    end

    always_comb begin
        fwd_d       = fwd_q;
        fill_d      = fill_q;
        pos_d       = pos_q;
        out_valid_d = out_valid_q;
        out_kmer_d  = out_kmer_q;
        out_pos_d   = out_pos_q;
        out_last_d  = out_last_q;
        out_rc_d    = out_rc_q;
`ifdef KMER_CANONICAL_EN
        rc_d        = rc_q;
`endif

        if (start_over) begin
            fwd_d       = '0;
            fill_d      = '0;
            pos_d       = '0;
            out_valid_d = 1'b0;
            out_kmer_d  = '0;
            out_pos_d   = '0;
            out_last_d  = 1'b0;
            out_rc_d    = 1'b0;
`ifdef KMER_CANONICAL_EN
            rc_d        = '0;
`endif
        end else begin
            if (beat) begin
                // Position counts every accepted beat, ambiguous ones included.
                pos_d = pos_q + 1'b1;
                if (in_invalid) begin
                    fwd_d  = '0;
                    fill_d = '0;
`ifdef KMER_CANONICAL_EN
                    rc_d   = '0;
`endif
                end else begin
                    fwd_d  = fwd_shift;
                    fill_d = fill_inc;
`ifdef KMER_CANONICAL_EN
                    rc_d   = rc_shift;
`endif
                end
                // End of sequence: the next base starts a fresh window at pos 0.
                if (in_last) begin
                    fwd_d  = '0;
                    fill_d = '0;
                    pos_d  = '0;
`ifdef KMER_CANONICAL_EN
                    rc_d   = '0;
`endif
                end
            end

            if (load) begin
                out_valid_d = 1'b1;
                out_kmer_d  = cand_kmer;
                out_pos_d   = pos_q;
                out_last_d  = in_last;
                out_rc_d    = cand_rc;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q       <= '0;
            fill_q      <= '0;
            pos_q       <= '0;
            out_valid_q <= 1'b0;
            out_kmer_q  <= '0;
            out_pos_q   <= '0;
            out_last_q  <= 1'b0;
            out_rc_q    <= 1'b0;
        end else begin
            fwd_q       <= fwd_d;
            fill_q      <= fill_d;
            pos_q       <= pos_d;
            out_valid_q <= out_valid_d;
            out_kmer_q  <= out_kmer_d;
            out_pos_q   <= out_pos_d;
            out_last_q  <= out_last_d;
            out_rc_q    <= out_rc_d;
        end
    end

`ifdef KMER_CANONICAL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc_q <= '0;
        end else begin
            rc_q <= rc_d;
        end
    end
`endif

    assign out_valid  = out_valid_q;
    assign out_kmer   = out_kmer_q;
    assign out_pos    = out_pos_q;
    assign out_last   = out_last_q;
    assign out_rc     = out_rc_q;
    assign fill_count = fill_q;

endmodule

// File: tb/tb_proj_kmer_window.sv
// tb/tb_proj_kmer_window.sv - directed self-checking bench for proj_kmer_window (K=4, 4-bit position)

module tb_proj_kmer_window;

    localparam int DB = 2;
    localparam int K  = 4;
    localparam int PB = 4;
    localparam int W  = K * DB;
    localparam int FW = $clog2(K + 1);

    localparam logic [1:0] A = 2'b00;
    localparam logic [1:0] C = 2'b01;
    localparam logic [1:0] G = 2'b10;
    localparam logic [1:0] T = 2'b11;

    logic          clk;
    logic          rst_n;
    logic          start_over;
    logic          in_valid;
    logic          in_ready;
    logic [DB-1:0] in_data;
    logic          in_invalid;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_kmer;
    logic [PB-1:0] out_pos;
    logic          out_last;
    logic          out_rc;
    logic [FW-1:0] fill_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0]  q_kmer[$];
    logic [PB-1:0] q_pos[$];
    logic          q_last[$];

    proj_kmer_window #(
        .DATA_BITS (DB),
        .KMER_LEN  (K),
        .POS_BITS  (PB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_over (start_over),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_invalid (in_invalid),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_kmer   (out_kmer),
        .out_pos    (out_pos),
        .out_last   (out_last),
        .out_rc     (out_rc),
        .fill_count (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transfers seen mid-cycle complete at the following rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q_kmer.push_back(out_kmer);
            q_pos.push_back(out_pos);
            q_last.push_back(out_last);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Presents one beat, waits (bounded) for acceptance, returns 1 time unit after the edge.
    task automatic beat(input logic [1:0] d, input logic inv = 1'b0, input logic last = 1'b0);
        int n;
        in_valid   = 1'b1;
        in_data    = d;
        in_invalid = inv;
        in_last    = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("beat_accept_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_invalid = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [W-1:0] kmer,
                              input logic [PB-1:0] pos, input logic last);
        chk({tag, "_valid"}, {63'd0, out_valid}, {63'd0, v});
        if (v) begin
            chk({tag, "_kmer"}, {56'd0, out_kmer}, {56'd0, kmer});
            chk({tag, "_pos"},  {60'd0, out_pos},  {60'd0, pos});
            chk({tag, "_last"}, {63'd0, out_last}, {63'd0, last});
        end
    endtask

    // start_over with a coincident beat: the beat must be refused and all state cleared.
    task automatic clear();
        start_over = 1'b1;
        in_valid   = 1'b1;
        in_data    = G;
        @(negedge clk);
        chk("start_over_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        start_over = 1'b0;
        in_valid   = 1'b0;
        chk("start_over_fill",  {61'd0, fill_count}, 64'd0);
        chk("start_over_valid", {63'd0, out_valid},  64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start_over = 1'b0;
        in_valid   = 1'b0;
        in_data    = A;
        in_invalid = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, out_valid},  64'd0);
        chk("rst_kmer",  {56'd0, out_kmer},   64'd0);
        chk("rst_pos",   {60'd0, out_pos},    64'd0);
        chk("rst_last",  {63'd0, out_last},   64'd0);
        chk("rst_rc",    {63'd0, out_rc},     64'd0);
        chk("rst_fill",  {61'd0, fill_count}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, in_ready}, 64'd1);

        // A,C,G,T,A back-to-back
        beat(A); beat(C); beat(G);
        chk("acg_fill", {61'd0, fill_count}, 64'd3);
        expect_out("acg", 1'b0, '0, '0, 1'b0);
        beat(T);
        expect_out("acgt", 1'b1, 8'h1B, 4'd3, 1'b0);
        chk("acgt_rc", {63'd0, out_rc}, 64'd0);
        beat(A);
        expect_out("cgta", 1'b1, 8'h6C, 4'd4, 1'b0);
        chk("cgta_fill", {61'd0, fill_count}, 64'd4);
        @(posedge clk);
        #1;
        expect_out("drained", 1'b0, '0, '0, 1'b0);
        clear();

        // A,C,N,G,T,A,C
        beat(A); beat(C); beat(A, 1'b1);
        chk("n_fill", {61'd0, fill_count}, 64'd0);
        expect_out("n", 1'b0, '0, '0, 1'b0);
        beat(G); beat(T); beat(A);
        expect_out("n_gta", 1'b0, '0, '0, 1'b0);
        beat(C);
        expect_out("n_gtac", 1'b1, 8'hB1, 4'd6, 1'b0);
        clear();

        // 5-base sequence with in_last, then a new sequence
        beat(A); beat(C); beat(G); beat(T);
        expect_out("seq_p3", 1'b1, 8'h1B, 4'd3, 1'b0);
        beat(A, 1'b0, 1'b1);
        expect_out("seq_p4", 1'b1, 8'h6C, 4'd4, 1'b1);
        chk("seq_end_fill", {61'd0, fill_count}, 64'd0);
        beat(A);
        expect_out("seq2_a", 1'b0, '0, '0, 1'b0);
        chk("seq2_fill", {61'd0, fill_count}, 64'd1);
        beat(C); beat(G); beat(T);
        expect_out("seq2_p3", 1'b1, 8'h1B, 4'd3, 1'b0);
        clear();

        // Short sequence yields nothing; start_over discards a partial window
        beat(A); beat(C, 1'b0, 1'b1);
        expect_out("short", 1'b0, '0, '0, 1'b0);
        chk("short_fill", {61'd0, fill_count}, 64'd0);
        beat(A); beat(C);
        clear();
        beat(G); beat(T); beat(A); beat(C);
        expect_out("after_so", 1'b1, 8'hB1, 4'd3, 1'b0);
        clear();

        // Backpressure: T,G,C,A,A,C with the sink stalled, then released
        q_kmer.delete();
        q_pos.delete();
        q_last.delete();
        out_ready = 1'b0;
        fork
            begin
                beat(T); beat(G); beat(C); beat(A); beat(A); beat(C);
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                chk("bp_ready", {63'd0, in_ready}, 64'd0);
                expect_out("bp_hold", 1'b1, 8'hE4, 4'd3, 1'b0);
                repeat (3) @(posedge clk);
                #1;
                expect_out("bp_stable", 1'b1, 8'hE4, 4'd3, 1'b0);
                out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("bp_count", q_kmer.size(), 64'd3);
        if (q_kmer.size() == 3) begin
            chk("bp0_kmer", {56'd0, q_kmer[0]}, 64'hE4);
            chk("bp0_pos",  {60'd0, q_pos[0]},  64'd3);
            chk("bp1_kmer", {56'd0, q_kmer[1]}, 64'h90);
            chk("bp1_pos",  {60'd0, q_pos[1]},  64'd4);
            chk("bp2_kmer", {56'd0, q_kmer[2]}, 64'h41);
            chk("bp2_pos",  {60'd0, q_pos[2]},  64'd5);
            chk("bp2_last", {63'd0, q_last[2]}, 64'd0);
        end
        clear();

        // Canonical selection
        beat(T); beat(T); beat(T); beat(T);
`ifdef KMER_CANONICAL_EN
        expect_out("tttt", 1'b1, 8'h00, 4'd3, 1'b0);
        chk("tttt_rc", {63'd0, out_rc}, 64'd1);
`else
        expect_out("tttt", 1'b1, 8'hFF, 4'd3, 1'b0);
        chk("tttt_rc", {63'd0, out_rc}, 64'd0);
`endif
        clear();
        beat(A); beat(C); beat(G); beat(T);
        expect_out("pal", 1'b1, 8'h1B, 4'd3, 1'b0);
        chk("pal_rc", {63'd0, out_rc}, 64'd0);
        clear();

        // Position wraps modulo 2^PB
        for (int i = 0; i < 16; i++) beat(A);
        expect_out("wrap_p15", 1'b1, 8'h00, 4'd15, 1'b0);
        beat(C);
        expect_out("wrap_p0", 1'b1, 8'h01, 4'd0, 1'b0);
        clear();

        // Asynchronous reset mid-stream
        beat(A); beat(C); beat(G); beat(T);
        expect_out("pre_rst", 1'b1, 8'h1B, 4'd3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid},  64'd0);
        chk("mid_rst_fill",  {61'd0, fill_count}, 64'd0);
        chk("mid_rst_kmer",  {56'd0, out_kmer},   64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        beat(G);
        expect_out("post_rst_g", 1'b0, '0, '0, 1'b0);
        chk("post_rst_fill", {61'd0, fill_count}, 64'd1);
        beat(T); beat(A); beat(C);
        expect_out("post_rst", 1'b1, 8'hB1, 4'd3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
